// File: rtl/lsu_rmw.sv
// Load/store unit between the core memory stage and a word-wide data RAM.
// Sub-word stores are performed as a two-cycle read-modify-write.
module lsu_rmw #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_req,
    input  logic             core_we,
    input  logic [2:0]       core_size,
    input  logic [WIDTH-1:0] core_addr,
    input  logic [WIDTH-1:0] core_wd,
    output logic [WIDTH-1:0] core_rd,
    output logic             core_err,
    output logic             core_stall,
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wr_data,
    input  logic [WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        StIdle,
        StCommit,
        StDone
    } state_e;

    localparam logic [2:0] SizeB  = 3'b000;
    localparam logic [2:0] SizeH  = 3'b001;
    localparam logic [2:0] SizeW  = 3'b010;
    localparam logic [2:0] SizeBu = 3'b100;
    localparam logic [2:0] SizeHu = 3'b101;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] wbuf_q, wbuf_d;
    logic             err_q, err_d;

    logic             illegal;
    logic             misaligned;
    logic             access_err;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] merged;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;

    // Size/alignment decode. Unsigned loads have no store counterpart.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (core_size)
            SizeB:   ;
            SizeH:   misaligned = core_addr[0];
            SizeW:   misaligned = |core_addr[1:0];
            SizeBu:  illegal = core_we;
            SizeHu: begin
                illegal    = core_we;
                misaligned = core_addr[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    assign access_err = illegal | misaligned;

    // Lane selection and extension of the combinational RAM read word.
    always_comb begin
        lane_byte = mem_rd_data[{core_addr[1:0], 3'b000} +: 8];
        lane_half = core_addr[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
        case (core_size)
            SizeB:   load_data = {{(WIDTH-8){lane_byte[7]}}, lane_byte};
            SizeH:   load_data = {{(WIDTH-16){lane_half[15]}}, lane_half};
            SizeBu:  load_data = {{(WIDTH-8){1'b0}}, lane_byte};
            SizeHu:  load_data = {{(WIDTH-16){1'b0}}, lane_half};
            default: load_data = mem_rd_data;
        endcase
    end

    // Merge store data into the current RAM word for SB/SH.
    always_comb begin
        merged = mem_rd_data;
        if (core_size[0]) begin
            if (core_addr[1]) begin
                merged[31:16] = core_wd[15:0];
            end else begin
                merged[15:0] = core_wd[15:0];
            end
        end else begin
            merged[{core_addr[1:0], 3'b000} +: 8] = core_wd[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wbuf_d  = wbuf_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_data = wbuf_q;
        unique case (state_q)
            StIdle: begin
                if (core_req) begin
                    addr_d  = core_addr;
                    state_d = StDone;
                    if (access_err) begin
                        err_d = 1'b1;
                        rd_d  = '0;
                    end else if (!core_we) begin
                        rd_d = load_data;
                    end else if (core_size[1]) begin
                        // Only SW reaches here with size bit 1 set.
                        wr_en   = 1'b1;
                        wr_data = core_wd;
                    end else begin
                        wbuf_d  = merged;
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                wr_en   = 1'b1;
                wr_data = wbuf_q;
                state_d = StDone;
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rd_q    <= '0;
            wbuf_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wbuf_q  <= wbuf_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced quiet during reset so an interrupted COMMIT never writes.
    assign mem_adr     = (state_q == StIdle) ? core_addr : addr_q;
    assign mem_wr_en   = wr_en & ~rst;
    assign mem_wr_data = wr_data;
    assign core_stall  = core_req & (state_q != StDone);
    assign core_rd     = ((state_q == StDone) && !rst) ? rd_q : '0;
    assign core_err    = (state_q == StDone) & err_q & ~rst;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a 256-word behavioural RAM.
module tb_lsu_rmw;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_X  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_err;
    logic        core_stall;
    logic        mem_wr_en;
    logic [31:0] mem_adr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic [31:0] ram [256];
    int          wr_count = 0;
    logic [31:0] last_wr = '0;

    int total = 0;
    int bad   = 0;

    lsu_rmw #(
        .WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_size  (core_size),
        .core_addr  (core_addr),
        .core_wd    (core_wd),
        .core_rd    (core_rd),
        .core_err   (core_err),
        .core_stall (core_stall),
        .mem_wr_en  (mem_wr_en),
        .mem_adr    (mem_adr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = ram[mem_adr[9:2]];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            ram[mem_adr[9:2]] <= mem_wr_data;
            wr_count          <= wr_count + 1;
            last_wr           <= mem_wr_data;
        end
    end

    // Drives one access starting in IDLE and returns its DONE-cycle result.
    // stalls stays at the bound if DONE never arrives.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int stalls);
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = wd;
        stalls    = 0;
        rd        = 'x;
        err       = 1'bx;
        #1;
        while (core_stall && stalls < 8) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (!core_stall) begin
            rd  = core_rd;
            err = core_err;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        err;
        int          st;
        rst       = 1'b1;
        core_req  = 1'b1;
        core_we   = 1'b1;
        core_size = SZ_W;
        core_addr = 32'h0000_0004;
        core_wd   = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (mem_wr_en !== 1'b0) begin
                bad++;
                $display("FAIL reset_wr_en[%0d]: got %b want 0", i, mem_wr_en);
            end
            total++;
            if (core_rd !== 32'h0) begin
                bad++;
                $display("FAIL reset_rd[%0d]: got %h want 00000000", i, core_rd);
            end
            total++;
            if (core_err !== 1'b0) begin
                bad++;
                $display("FAIL reset_err[%0d]: got %b want 0", i, core_err);
            end
        end
        @(negedge clk);
        rst      = 1'b0;
        core_req = 1'b0;
        total++;
        if (wr_count !== 0) begin
            bad++;
            $display("FAIL reset_no_write: got %0d writes want 0", wr_count);
        end
        access(1'b1, SZ_W, 32'h0000_0000, 32'h0000_0000, rd, err, st);
        total++;
        if (st !== 1) begin
            bad++;
            $display("FAIL first_access_stalls: got %0d want 1", st);
        end
    endtask

    task automatic test_sw_lw();
        logic [31:0] rd;
        logic        err;
        int          st;
        int          n0;
        n0 = wr_count;
        access(1'b1, SZ_W, 32'h0000_0010, 32'hDEAD_BEEF, rd, err, st);
        total++;
        if (st !== 1) begin
            bad++;
            $display("FAIL sw_stalls: got %0d want 1", st);
        end
        total++;
        if (wr_count - n0 !== 1) begin
            bad++;
            $display("FAIL sw_write_count: got %0d want 1", wr_count - n0);
        end
        total++;
        if (last_wr !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL sw_wr_data: got %h want deadbeef", last_wr);
        end
        access(1'b0, SZ_W, 32'h0000_0010, 32'h0, rd, err, st);
        total++;
        if (st !== 1) begin
            bad++;
            $display("FAIL lw_stalls: got %0d want 1", st);
        end
        total++;
        if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
            bad++;
            $display("FAIL lw_data: got %h err %b want deadbeef err 0", rd, err);
        end
    endtask

    task automatic test_rmw();
        logic [31:0] rd;
        logic        err;
        int          st;
        int          n0;
        access(1'b1, SZ_W, 32'h0000_0020, 32'h1122_3344, rd, err, st);
        n0 = wr_count;
        access(1'b1, SZ_B, 32'h0000_0021, 32'h1234_56AA, rd, err, st);
        total++;
        if (st !== 2) begin
            bad++;
            $display("FAIL sb_stalls: got %0d want 2", st);
        end
        total++;
        if (wr_count - n0 !== 1 || last_wr !== 32'h1122_AA44) begin
            bad++;
            $display("FAIL sb_merge: got %h (%0d writes) want 1122aa44 (1 write)", last_wr,
                     wr_count - n0);
        end
        n0 = wr_count;
        access(1'b1, SZ_H, 32'h0000_0022, 32'h9876_55CC, rd, err, st);
        total++;
        if (st !== 2) begin
            bad++;
            $display("FAIL sh_stalls: got %0d want 2", st);
        end
        total++;
        if (wr_count - n0 !== 1 || last_wr !== 32'h55CC_AA44) begin
            bad++;
            $display("FAIL sh_merge: got %h (%0d writes) want 55ccaa44 (1 write)", last_wr,
                     wr_count - n0);
        end
    endtask

    task automatic test_loads();
        logic [31:0] rd;
        logic        err;
        int          st;
        logic [2:0]  sz   [4] = '{SZ_B, SZ_BU, SZ_H, SZ_HU};
        logic [31:0] ad   [4] = '{32'h30, 32'h31, 32'h32, 32'h32};
        logic [31:0] want [4] = '{32'hFFFF_FFFF, 32'h0000_00F0, 32'hFFFF_8081, 32'h0000_8081};
        access(1'b1, SZ_W, 32'h0000_0030, 32'h8081_F0FF, rd, err, st);
        for (int i = 0; i < 4; i++) begin
            access(1'b0, sz[i], ad[i], 32'h0, rd, err, st);
            total++;
            if (rd !== want[i] || err !== 1'b0 || st !== 1) begin
                bad++;
                $display("FAIL load_ext[%0d]: got %h err %b stalls %0d want %h err 0 stalls 1",
                         i, rd, err, st, want[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        err;
        int          st;
        int          n0;
        logic        we   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  sz   [4] = '{SZ_W, SZ_H, SZ_X, SZ_BU};
        logic [31:0] ad   [4] = '{32'h41, 32'h43, 32'h40, 32'h40};
        access(1'b1, SZ_W, 32'h0000_0040, 32'hCAFE_F00D, rd, err, st);
        access(1'b0, SZ_W, 32'h0000_0040, 32'h0, rd, err, st);
        n0 = wr_count;
        for (int i = 0; i < 4; i++) begin
            access(we[i], sz[i], ad[i], 32'h1234_5678, rd, err, st);
            total++;
            if (err !== 1'b1 || rd !== 32'h0 || st !== 1) begin
                bad++;
                $display("FAIL err_case[%0d]: got err %b rd %h stalls %0d want err 1 rd 0 stalls 1",
                         i, err, rd, st);
            end
        end
        total++;
        if (wr_count !== n0) begin
            bad++;
            $display("FAIL err_no_write: got %0d writes want 0", wr_count - n0);
        end
        total++;
        if (ram[16] !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL err_ram_intact: got %h want cafef00d", ram[16]);
        end
        access(1'b0, SZ_W, 32'h0000_0040, 32'h0, rd, err, st);
        total++;
        if (err !== 1'b0 || rd !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL err_clears: got err %b rd %h want err 0 rd cafef00d", err, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        err;
        int          st;
        logic        exp_stall;
        access(1'b1, SZ_B, 32'h0000_0013, 32'h0000_005A, rd, err, st);
        // Request held high: each DONE is followed directly by a new IDLE access.
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_size = SZ_W;
        core_addr = 32'h0000_0010;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_stall = (i % 2 == 0);
            total++;
            if (core_stall !== exp_stall) begin
                bad++;
                $display("FAIL b2b_stall[%0d]: got %b want %b", i, core_stall, exp_stall);
            end
            if (!exp_stall) begin
                total++;
                if (core_rd !== 32'h5AAD_BEEF) begin
                    bad++;
                    $display("FAIL b2b_rd[%0d]: got %h want 5aadbeef", i, core_rd);
                end
            end
        end
    endtask

    task automatic test_reset_commit();
        logic [31:0] rd;
        logic        err;
        int          st;
        int          n0;
        access(1'b1, SZ_W, 32'h0000_0050, 32'h0102_0304, rd, err, st);
        n0 = wr_count;
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = 1'b1;
        core_size = SZ_B;
        core_addr = 32'h0000_0050;
        core_wd   = 32'h0000_00EE;
        #1;
        total++;
        if (core_stall !== 1'b1) begin
            bad++;
            $display("FAIL rc_idle_stall: got %b want 1", core_stall);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (mem_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL rc_wr_en: got %b want 0", mem_wr_en);
        end
        @(negedge clk);
        rst      = 1'b0;
        core_req = 1'b0;
        total++;
        if (wr_count !== n0) begin
            bad++;
            $display("FAIL rc_no_write: got %0d writes want 0", wr_count - n0);
        end
        access(1'b0, SZ_W, 32'h0000_0050, 32'h0, rd, err, st);
        total++;
        if (rd !== 32'h0102_0304 || st !== 1) begin
            bad++;
            $display("FAIL rc_readback: got %h stalls %0d want 01020304 stalls 1", rd, st);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_rmw();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_commit();
        @(negedge clk);
        core_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit between the core's memory stage and the word-wide data RAM. It accepts byte, halfword and word loads and stores, produces sign- or zero-extended load data, and stalls the core while an access is in flight. The RAM has only full-word write enable and combinational read, so sub-word stores are done as a two-cycle read-modify-write. Misaligned or illegal accesses are flagged and never reach memory.

## Interface
Parameters:
- WIDTH, 32, data and address width; must be 32.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  1  access request; held with all core_* inputs stable while core_stall=1
- core_we  in  1  1 = store, 0 = load
- core_size  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes illegal
- core_addr  in  WIDTH  byte address
- core_wd  in  WIDTH  store data; low byte/halfword used for SB/SH
- core_rd  out  WIDTH  extended load data; valid in DONE state
- core_err  out  1  misaligned or illegal access; valid in DONE state
- core_stall  out  1  core must hold its request
- mem_wr_en  out  1  RAM word write enable
- mem_adr  out  WIDTH  RAM byte address (RAM indexes bits [9:2])
- mem_wr_data  out  WIDTH  RAM write word
- mem_rd_data  in  WIDTH  RAM combinational read word for mem_adr

## Operation
- States: IDLE, COMMIT, DONE.
- IDLE, core_req=0: no memory access, mem_wr_en=0, stall=0.
- IDLE, core_req=1: mem_adr=core_addr; core_addr latched into addr_q. Then:
  - illegal size, or misaligned (halfword with addr[0]=1; word with addr[1:0]≠00; LBU/LHU with we=1 counts as illegal): err_q←1, rd_q←0, no write, → DONE.
  - load: select byte addr[1:0] / halfword addr[1] of mem_rd_data, sign-extend (LB/LH) or zero-extend (LBU/LHU), LW passes word; result → rd_q, → DONE.
  - SW: mem_wr_en=1, mem_wr_data=core_wd this cycle, → DONE.
  - SB/SH: merge core_wd[7:0]/[15:0] into mem_rd_data at byte lane addr[1:0] / halfword lane addr[1]; merged word → wbuf_q, → COMMIT.
- COMMIT: mem_adr=addr_q, mem_wr_data=wbuf_q, mem_wr_en=1, → DONE.
- DONE: core_rd=rd_q, core_err=err_q, stall=0, no memory access, → IDLE unconditionally; err_q cleared on leaving.
- core_stall = core_req & (state≠DONE). Core advances on the cycle core_stall=0 with core_req=1.
- Stores leave rd_q unchanged; core_rd on a store's DONE cycle is don't-care.
- mem_adr = core_addr in IDLE, addr_q otherwise; mem_wr_en=0 in every state/case not listed above.

## Timing
- Reset: state=IDLE, rd_q=0, wbuf_q=0, addr_q=0, err_q=0; core_rd=0, core_err=0, mem_wr_en=0 while rst=1 regardless of inputs.
- Load, SW, error: 1 stall cycle (IDLE), result in cycle 2 (DONE).
- SB/SH: 2 stall cycles (IDLE, COMMIT), write in cycle 2, DONE in cycle 3.
- Back-to-back: a request held high after DONE is taken as a new access in the following IDLE cycle; minimum 2 cycles per access.
- Reset asserted in COMMIT: no write occurs that cycle; state→IDLE.
- Read-after-store: a load issued after a store's DONE sees the stored data (RAM written at COMMIT/IDLE edge).
- core_req dropping while stalled is a protocol violation; behaviour undefined.

## Test plan
- Reset then idle: rst=1 for 2 cycles with core_req=1 -> mem_wr_en=0, core_rd=0, core_err=0; after release first access starts in IDLE.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> one mem_wr_en pulse with mem_wr_data=0xDEADBEEF; load DONE core_rd=0xDEADBEEF, each access stalls exactly 1 cycle.
- Word 0x11223344 at 0x20; SB 0xAA to 0x21 -> COMMIT writes 0x1122AA44, 2 stall cycles; then SH 0x55CC to 0x22 -> writes 0x55CCAA44.
- Word 0x8081F0FF at 0x30: LB 0x30 -> 0xFFFFFFFF; LBU 0x31 -> 0x000000F0; LH 0x32 -> 0xFFFF8081; LHU 0x32 -> 0x00008081.
- SW to 0x41, LH 0x43, size 011 -> core_err=1 in DONE, mem_wr_en never asserted, RAM at 0x40 unchanged, core_rd=0.
- SB to 0x50 with rst pulsed during COMMIT -> no write; subsequent LW 0x50 returns original word.
